cache_req_master: RTL and testbench
===================================

// Module: cache_req_master
// PURPOSE
//  Request initiator for multilevel_cache_top. Queues read/write commands from an upstream
//  valid/ready port and drives them onto the cache's {opcode,tag,data} vector_in bus, one at
//  a time. After a fixed latency it samples the cache's data_out/hit_miss_out and returns
//  them on a valid/ready response port. Keeps saturating hit/miss statistics. Sits between
//  the processor-side request logic and the cache hierarchy.
// PARAMETERS
//  CACHE_TAG_WIDTH   4   tag width; matches the cache
//  CACHE_DATA_WIDTH  4   data width; matches the cache
//  OPCODE_WIDTH      2   opcode width; 2'b00 NOP, 2'b01 read, 2'b10 write, 2'b11 illegal
//  RESP_LATENCY      4   cycles a request is held on vector_out before sampling; must be >=1
//  CMD_DEPTH         4   command FIFO depth; power of two, >=2
//  CNT_WIDTH         16  width of hit_count/miss_count
// PORTS
//  clk           in   1      clock; all logic on rising edge
//  rst_n         in   1      asynchronous active-low reset
//  cmd_valid     in   1      upstream command valid
//  cmd_ready     out  1      FIFO not full
//  cmd_op        in   OPCODE_WIDTH       command opcode
//  cmd_tag       in   CACHE_TAG_WIDTH    command tag
//  cmd_data      in   CACHE_DATA_WIDTH   write data; don't-care for reads
//  vector_out    out  OPCODE+TAG+DATA    to cache vector_in = {op,tag,data}, registered
//  cache_data_in in   CACHE_DATA_WIDTH   from cache data_out
//  cache_hit_in  in   1      from cache hit_miss_out (1 = hit)
//  rsp_valid     out  1      response valid
//  rsp_ready     in   1      downstream accepts response
//  rsp_data      out  CACHE_DATA_WIDTH   sampled cache data
//  rsp_hit       out  1      sampled hit flag
//  rsp_tag       out  CACHE_TAG_WIDTH    tag of the request being answered
//  busy          out  1      FSM not IDLE or FIFO not empty
//  hit_count     out  CNT_WIDTH          saturating hit counter
//  miss_count    out  CNT_WIDTH          saturating miss counter
//  clr_stats     in   1      synchronous clear of both counters
// BEHAVIOUR
//  Reset: FIFO empty; state IDLE; vector_out=0; rsp_valid=0; rsp_data/rsp_hit/rsp_tag=0;
//   counters=0; cmd_ready=1. Asserting reset mid-operation aborts the in-flight request and
//   discards the FIFO; no response is produced for aborted commands.
//  FIFO: push on cmd_valid&&cmd_ready. cmd_ready=!full only, with no combinational path
//   from pop, so a push is refused when full even if a pop occurs in the same cycle.
//   Commands issue in push order.
//  FSM IDLE: vector_out=NOP (all zeros). If the FIFO is non-empty, pop. op==2'b11 or 2'b00:
//   drop it, stay IDLE, no cache access, no response. Otherwise latch op/tag/data -> ISSUE.
//  ISSUE/WAIT: vector_out={op,tag,data} for exactly RESP_LATENCY cycles. Wait counter loads
//   RESP_LATENCY-1 and decrements. The edge ending the last of these cycles samples
//   cache_data_in/cache_hit_in into rsp_data/rsp_hit and updates the counters -> RESP.
//  RESP: vector_out=NOP; rsp_valid=1, rsp_* stable until rsp_valid&&rsp_ready -> IDLE.
//   At least one NOP cycle separates consecutive requests, even when the commands are identical.
//  Latency: pop at edge t -> vector_out valid t+1..t+RESP_LATENCY -> rsp_valid from t+RESP_LATENCY+1.
//  Reads and writes both produce responses and both update statistics.
//  Counters: +1 hit_count if cache_hit_in, else +1 miss_count, at the sample edge; saturate
//   at all-ones. clr_stats wins over a coincident increment.
// TESTING
//  1 Reset pulse mid-WAIT -> vector_out=0, rsp_valid=0, cmd_ready=1, counters 0, busy=0.
//  2 Read op=01 tag=1100; cache_data_in=4'h3, cache_hit_in=0 -> vector_out=10'b01_1100_0000
//    for 4 cycles, then rsp_valid, rsp_data=3, rsp_hit=0, rsp_tag=C, miss_count=1.
//  3 Two back-to-back reads of tag 0101 with rsp_ready=1 -> >=1 NOP cycle between them on
//    vector_out; two responses in order.
//  4 rsp_ready=0, cmd_valid held high -> exactly 5 commands accepted (1 in flight + 4 queued),
//    then cmd_ready=0; release rsp_ready -> 5 responses in push order.
//  5 Command op=11 -> accepted, vector_out stays NOP, no rsp_valid, counters unchanged.
//  6 CNT_WIDTH=2, 4 hits -> hit_count=3 (saturated); clr_stats on a sample edge -> hit_count=0.

Source files
------------

// File: rtl/cache_req_master_if.sv
// cache_req_master_if
//   Upstream command port and downstream response port of cache_req_master.
//   Both are valid/ready handshakes.
//   master : the side that issues commands and consumes responses (processor side)
//   slave  : the side that accepts commands and produces responses (cache_req_master)
//   Signals:
//     cmd_valid/cmd_ready          command handshake
//     cmd_op/cmd_tag/cmd_data      command payload
//     rsp_valid/rsp_ready          response handshake
//     rsp_data/rsp_hit/rsp_tag     response payload
interface cache_req_master_if #(
    parameter int OPCODE_WIDTH     = 2,
    parameter int CACHE_TAG_WIDTH  = 4,
    parameter int CACHE_DATA_WIDTH = 4
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [OPCODE_WIDTH-1:0]     cmd_op;
    logic [CACHE_TAG_WIDTH-1:0]  cmd_tag;
    logic [CACHE_DATA_WIDTH-1:0] cmd_data;

    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [CACHE_DATA_WIDTH-1:0] rsp_data;
    logic                        rsp_hit;
    logic [CACHE_TAG_WIDTH-1:0]  rsp_tag;

    modport master (
        output cmd_valid, cmd_op, cmd_tag, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_hit, rsp_tag
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_tag, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_hit, rsp_tag
    );
endinterface

// File: rtl/cache_req_master.sv
// cache_req_master
//   Request initiator for the cache hierarchy. Commands are queued in a small
//   FIFO and issued one at a time on vector_out = {op,tag,data}. Each request
//   is held for RESP_LATENCY cycles; the edge closing the last of them samples
//   the cache's data/hit outputs into a response that is then held on the
//   response port until accepted. NOP (2'b00) and illegal (2'b11) opcodes are
//   dropped without touching the cache. Saturating hit/miss counters are kept.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     bus (slave)         command in / response out (valid/ready)
//     vector_out          registered request to the cache vector_in
//     cache_data_in       cache data_out
//     cache_hit_in        cache hit_miss_out (1 = hit)
//     busy                request in progress or commands queued
//     hit_count           saturating hit counter
//     miss_count          saturating miss counter
//     clr_stats           synchronous clear of both counters
module cache_req_master #(
    parameter int CACHE_TAG_WIDTH  = 4,
    parameter int CACHE_DATA_WIDTH = 4,
    parameter int OPCODE_WIDTH     = 2,
    parameter int RESP_LATENCY     = 4,
    parameter int CMD_DEPTH        = 4,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    cache_req_master_if.slave           bus,
    output logic [OPCODE_WIDTH+CACHE_TAG_WIDTH+CACHE_DATA_WIDTH-1:0] vector_out,
    input  logic [CACHE_DATA_WIDTH-1:0] cache_data_in,
    input  logic                        cache_hit_in,
    output logic                        busy,
    output logic [CNT_WIDTH-1:0]        hit_count,
    output logic [CNT_WIDTH-1:0]        miss_count,
    input  logic                        clr_stats
);

    localparam int AW = $clog2(CMD_DEPTH);
    localparam int LW = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;

    localparam logic [OPCODE_WIDTH-1:0] OP_READ  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_WRITE = OPCODE_WIDTH'(2);

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0]     op;
        logic [CACHE_TAG_WIDTH-1:0]  tag;
        logic [CACHE_DATA_WIDTH-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO. Pointers carry one extra wrap bit so full and empty
    // are distinguishable without a separate occupancy counter.
    // ------------------------------------------------------------------
    cmd_t        fifo_mem [CMD_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    cmd_t        head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Ready depends only on registered pointers, so a same-cycle pop never
    // opens a slot for a push.
    assign bus.cmd_ready = !full;
    assign push          = bus.cmd_valid && !full;
    assign head          = fifo_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= '{op: bus.cmd_op, tag: bus.cmd_tag, data: bus.cmd_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    state_t          state;
    state_t          state_d;
    logic [LW-1:0]   wait_cnt;
    logic            load;
    logic            sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        load    = 1'b0;
        sample  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    // NOP and illegal opcodes are consumed here and never
                    // reach the cache.
                    if (head.op == OP_READ || head.op == OP_WRITE) begin
                        load    = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (wait_cnt == '0) begin
                    sample  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // vector_out is non-zero only while in ISSUE: set on load, cleared on
    // the sample edge. The IDLE state that always follows RESP guarantees
    // at least one NOP cycle between requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vector_out <= '0;
            wait_cnt   <= '0;
        end else begin
            if (load) begin
                vector_out <= head;
                wait_cnt   <= LW'(RESP_LATENCY - 1);
            end else if (sample) begin
                vector_out <= '0;
            end else if (state == ISSUE) begin
                wait_cnt   <= wait_cnt - LW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Response registers; the tag comes straight from the held request.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_data <= '0;
            bus.rsp_hit  <= 1'b0;
            bus.rsp_tag  <= '0;
        end else if (sample) begin
            bus.rsp_data <= cache_data_in;
            bus.rsp_hit  <= cache_hit_in;
            bus.rsp_tag  <= vector_out[CACHE_DATA_WIDTH +: CACHE_TAG_WIDTH];
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign busy          = (state != IDLE) || !empty;

    // ------------------------------------------------------------------
    // Statistics; clear takes priority over a coincident increment.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (clr_stats) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (sample) begin
            if (cache_hit_in) begin
                if (hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
            end else begin
                if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_cache_req_master.sv
module tb_cache_req_master;

    localparam int OW = 2;
    localparam int TW = 4;
    localparam int DW = 4;
    localparam int L  = 4;
    localparam int D  = 4;
    localparam int CW = 2;
    localparam int VW = OW + TW + DW;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [VW-1:0] vector_out;
    logic [DW-1:0] cache_data_in = '0;
    logic          cache_hit_in = 1'b0;
    logic          busy;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;
    logic          clr_stats = 1'b0;

    cache_req_master_if #(.OPCODE_WIDTH(OW), .CACHE_TAG_WIDTH(TW), .CACHE_DATA_WIDTH(DW)) bus ();

    cache_req_master #(
        .CACHE_TAG_WIDTH(TW), .CACHE_DATA_WIDTH(DW), .OPCODE_WIDTH(OW),
        .RESP_LATENCY(L), .CMD_DEPTH(D), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .vector_out(vector_out), .cache_data_in(cache_data_in),
        .cache_hit_in(cache_hit_in), .busy(busy),
        .hit_count(hit_count), .miss_count(miss_count), .clr_stats(clr_stats)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] op;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } cmd_s;

    // Reference model: accepted legal commands in order, per-cycle history of
    // what the cache drove and what appeared on vector_out, abstract counters.
    cmd_s          expq[$];
    logic [VW-1:0] vhist [4096];
    logic [DW-1:0] dhist [4096];
    logic          hhist [4096];
    int            cyc = 0;
    int            ncmp = 0;
    int            nfail = 0;
    int            nrsp = 0;
    int            hm = 0;
    int            mm = 0;
    bit            prev_v = 0;
    logic [DW-1:0] pd;
    logic [TW-1:0] pt;
    logic          ph;
    bit            acc, taken, clr_edge;
    bit            fix_en = 0;
    logic [DW-1:0] fix_d = '0;
    logic          fix_h = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: account handshakes for the coming edge, drive the cache
    // outputs for the new cycle, then observe and score at the negedge.
    task automatic tick();
        cmd_s e;
        acc      = bus.cmd_valid && bus.cmd_ready && rst_n;
        taken    = bus.rsp_valid && bus.rsp_ready;
        clr_edge = clr_stats;
        if (acc && (bus.cmd_op == 2'b01 || bus.cmd_op == 2'b10))
            expq.push_back('{op: bus.cmd_op, tag: bus.cmd_tag, data: bus.cmd_data});
        @(posedge clk);
        cyc++;
        #1;
        cache_data_in = fix_en ? fix_d : DW'($urandom);
        cache_hit_in  = fix_en ? fix_h : 1'($urandom);
        dhist[cyc & 4095] = cache_data_in;
        hhist[cyc & 4095] = cache_hit_in;
        @(negedge clk);
        vhist[cyc & 4095] = vector_out;
        if (rst_n) begin
            if (clr_edge) begin
                hm = 0;
                mm = 0;
            end
            if (bus.rsp_valid && (!prev_v || taken)) begin
                nrsp++;
                chk("rsp_expected", 32'(expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("rsp_tag", bus.rsp_tag, e.tag);
                    chk("rsp_data", bus.rsp_data, dhist[(cyc - 1) & 4095]);
                    chk("rsp_hit", bus.rsp_hit, hhist[(cyc - 1) & 4095]);
                    for (int k = 1; k <= L; k++)
                        chk("vec_window", vhist[(cyc - k) & 4095], {e.op, e.tag, e.data});
                    chk("vec_gap", vhist[(cyc - L - 1) & 4095], 0);
                    if (!clr_edge) begin
                        if (hhist[(cyc - 1) & 4095]) hm = (hm < CMAX) ? hm + 1 : CMAX;
                        else                         mm = (mm < CMAX) ? mm + 1 : CMAX;
                    end
                end
            end else if (bus.rsp_valid) begin
                chk("rsp_hold_data", bus.rsp_data, pd);
                chk("rsp_hold_tag", bus.rsp_tag, pt);
                chk("rsp_hold_hit", bus.rsp_hit, ph);
            end
            chk("hit_count", hit_count, hm);
            chk("miss_count", miss_count, mm);
            prev_v = bus.rsp_valid;
            pd = bus.rsp_data;
            pt = bus.rsp_tag;
            ph = bus.rsp_hit;
        end
    endtask

    task automatic send(input logic [OW-1:0] op, input logic [TW-1:0] tag, input logic [DW-1:0] data);
        int n;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_tag   = tag;
        bus.cmd_data  = data;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc && n < 20);
        chk("send_accepted", 32'(acc), 1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (nrsp < target && n < 40) begin
            tick();
            n++;
        end
        chk("rsp_arrived", nrsp, target);
    endtask

    task automatic drain();
        int n;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        n = 0;
        while ((busy || bus.rsp_valid) && n < 300) begin
            tick();
            n++;
        end
        tick();
        chk("drain_queue_empty", expq.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        expq.delete();
        hm = 0;
        mm = 0;
        prev_v = 0;
        chk("rst_vector_out", vector_out, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_tag", bus.rsp_tag, 0);
        chk("rst_rsp_hit", bus.rsp_hit, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt, base;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_tag   = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b1;

        // Power-on reset
        #2;
        do_reset();
        tick();

        // Reset mid-WAIT with a second command still queued: nothing survives
        send(2'b01, 4'h9, 4'h1);
        send(2'b10, 4'h2, 4'h7);
        tick();
        do_reset();
        base = nrsp;
        repeat (12) begin
            tick();
            chk("post_rst_vec_nop", vector_out, 0);
        end
        chk("post_rst_no_rsp", nrsp, base);

        // Single read, miss, cache data 3
        fix_en = 1; fix_d = 4'h3; fix_h = 1'b0;
        base = nrsp;
        send(2'b01, 4'hC, 4'h0);
        wait_rsp(base + 1);
        chk("t2_rsp_data", bus.rsp_data, 4'h3);
        chk("t2_rsp_hit", bus.rsp_hit, 0);
        chk("t2_rsp_tag", bus.rsp_tag, 4'hC);
        chk("t2_miss", miss_count, 1);
        chk("t2_vec", vhist[(cyc - 1) & 4095], 10'b01_1100_0000);
        fix_en = 0;
        drain();

        // Two identical back-to-back reads: gap checked by the scoreboard
        base = nrsp;
        send(2'b01, 4'h5, 4'hA);
        send(2'b01, 4'h5, 4'hA);
        wait_rsp(base + 2);
        drain();

        // Backpressure: 1 in flight + D queued, then full
        bus.rsp_ready = 1'b0;
        base = nrsp;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01 + OW'($urandom_range(0, 1));
        bus.cmd_tag   = TW'($urandom);
        bus.cmd_data  = DW'($urandom);
        cnt = 0;
        repeat (20) begin
            tick();
            if (acc) begin
                cnt++;
                bus.cmd_op   = 2'b01 + OW'($urandom_range(0, 1));
                bus.cmd_tag  = TW'($urandom);
                bus.cmd_data = DW'($urandom);
            end
        end
        chk("bp_accepted", cnt, D + 1);
        chk("bp_cmd_ready", bus.cmd_ready, 0);
        drain();
        chk("bp_responses", nrsp - base, D + 1);

        // Illegal and NOP opcodes are swallowed
        base = nrsp;
        send(2'b11, 4'hF, 4'hF);
        send(2'b00, 4'h3, 4'h3);
        repeat (10) begin
            tick();
            chk("drop_vec_nop", vector_out, 0);
            chk("drop_no_rsp_valid", bus.rsp_valid, 0);
        end
        chk("drop_no_rsp", nrsp, base);
        chk("drop_busy", busy, 0);

        // Saturation and clear-wins
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        fix_en = 1; fix_h = 1'b1; fix_d = 4'h6;
        for (int i = 0; i < 4; i++) begin
            base = nrsp;
            send(2'b01, TW'(i), 4'h0);
            wait_rsp(base + 1);
        end
        drain();
        chk("sat_hit_count", hit_count, CMAX);
        clr_stats = 1'b1;
        base = nrsp;
        send(2'b10, 4'h8, 4'h4);
        wait_rsp(base + 1);
        chk("clr_wins_hit", hit_count, 0);
        clr_stats = 1'b0;
        fix_en = 0;
        drain();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bus.cmd_valid = 1'($urandom);
            bus.cmd_op    = OW'($urandom);
            bus.cmd_tag   = TW'($urandom);
            bus.cmd_data  = DW'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            clr_stats     = ($urandom_range(0, 40) == 0);
            tick();
        end
        clr_stats = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
